// File: rtl/a5_interrupt_controller.sv
// Prioritised, nestable interrupt controller for the A5 core: edge-latched requests,
// per-line mask, in-service tracking for nesting, and vector generation on acknowledge.
module a5_interrupt_controller #(
  parameter int               NUM_IRQ       = 4,
  parameter int               ID_W          = 2,
  parameter int               ADDR_W        = 12,
  parameter logic [ADDR_W-1:0] VECTOR_BASE  = 12'hF00,
  parameter int               VECTOR_STRIDE = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  input  logic               IEN,
  input  logic               MASK_WR,
  input  logic [NUM_IRQ-1:0] MASK_DATA,
  input  logic               INT_ACK,
  input  logic               RETI,
  output logic               INT_REQ,
  output logic [ID_W-1:0]    INT_ID,
  output logic               VECTOR_VALID,
  output logic [ADDR_W-1:0]  VECTOR_ADDR,
  output logic [NUM_IRQ-1:0] PENDING,
  output logic [NUM_IRQ-1:0] IN_SERVICE,
  output logic [NUM_IRQ-1:0] MASK_Q,
  output logic               RETI_ERR
);

  typedef enum logic [1:0] {IDLE, REQ, VECTOR} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               int_req_q, int_req_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic               vector_valid_q, vector_valid_d;
  logic [ADDR_W-1:0]  vector_addr_q, vector_addr_d;
  logic               reti_err_q, reti_err_d;

  logic [NUM_IRQ-1:0] rise, eligible, ack_clr, reti_clr, id_onehot;
  logic               win_found, isr_found, win_ok;
  logic [ID_W-1:0]    win_idx, isr_idx;

  assign rise      = s2_q & ~s3_q;
  assign eligible  = pending_q & ~mask_q;
  assign id_onehot = NUM_IRQ'(1) << int_id_q;
  // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority service level.
  assign reti_clr  = RETI ? (isr_q & (~isr_q + NUM_IRQ'(1))) : '0;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    isr_found = 1'b0;
    isr_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
      if (isr_q[i]) begin
        isr_found = 1'b1;
        isr_idx   = ID_W'(i);
      end
    end
    win_ok = win_found && (!isr_found || (win_idx < isr_idx));
  end

  always_comb begin
    state_d        = state_q;
    int_req_d      = int_req_q;
    int_id_d       = int_id_q;
    vector_valid_d = 1'b0;
    vector_addr_d  = vector_addr_q;
    ack_clr        = '0;
    case (state_q)
      IDLE: begin
        if (IEN && win_ok) begin
          state_d   = REQ;
          int_id_d  = win_idx;
          int_req_d = 1'b1;
        end
      end
      REQ: begin
        // Acknowledge wins over a simultaneous enable drop or mask change.
        if (INT_ACK) begin
          state_d        = VECTOR;
          ack_clr        = id_onehot;
          int_req_d      = 1'b0;
          vector_valid_d = 1'b1;
          vector_addr_d  = VECTOR_BASE + ADDR_W'(int_id_q) * ADDR_W'(VECTOR_STRIDE);
        end else if (!IEN || mask_q[int_id_q]) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      VECTOR: state_d = IDLE;
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase
    pending_d  = (pending_q & ~ack_clr) | rise;
    isr_d      = (isr_q & ~reti_clr) | ack_clr;
    mask_d     = MASK_WR ? MASK_DATA : mask_q;
    reti_err_d = reti_err_q | (RETI && (isr_q == '0));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      pending_q      <= '0;
      isr_q          <= '0;
      mask_q         <= '1;
      int_req_q      <= 1'b0;
      int_id_q       <= '0;
      vector_valid_q <= 1'b0;
      vector_addr_q  <= '0;
      reti_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= IRQ_IN;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      pending_q      <= pending_d;
      isr_q          <= isr_d;
      mask_q         <= mask_d;
      int_req_q      <= int_req_d;
      int_id_q       <= int_id_d;
      vector_valid_q <= vector_valid_d;
      vector_addr_q  <= vector_addr_d;
      reti_err_q     <= reti_err_d;
    end
  end

  assign INT_REQ      = int_req_q;
  assign INT_ID       = int_id_q;
  assign VECTOR_VALID = vector_valid_q;
  assign VECTOR_ADDR  = vector_addr_q;
  assign PENDING      = pending_q;
  assign IN_SERVICE   = isr_q;
  assign MASK_Q       = mask_q;
  assign RETI_ERR     = reti_err_q;

endmodule

// File: tb/tb_a5_interrupt_controller.sv
// Scoreboard bench for a5_interrupt_controller: directed scenarios then random traffic,
// checked against a behavioural priority/nesting model.
module tb_a5_interrupt_controller;

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  IRQ_IN;
  logic        IEN, MASK_WR, INT_ACK, RETI;
  logic [3:0]  MASK_DATA;
  logic        INT_REQ, VECTOR_VALID, RETI_ERR;
  logic [1:0]  INT_ID;
  logic [11:0] VECTOR_ADDR;
  logic [3:0]  PENDING, IN_SERVICE, MASK_Q;

  a5_interrupt_controller dut (
    .CLK(clk), .RST(RST), .IRQ_IN(IRQ_IN), .IEN(IEN), .MASK_WR(MASK_WR),
    .MASK_DATA(MASK_DATA), .INT_ACK(INT_ACK), .RETI(RETI), .INT_REQ(INT_REQ),
    .INT_ID(INT_ID), .VECTOR_VALID(VECTOR_VALID), .VECTOR_ADDR(VECTOR_ADDR),
    .PENDING(PENDING), .IN_SERVICE(IN_SERVICE), .MASK_Q(MASK_Q), .RETI_ERR(RETI_ERR)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus values applied by the next call to cyc()
  logic [3:0] irq_v = '0, mdata_v = '0;
  logic       ien_v = 1'b0, mwr_v = 1'b0, ack_v = 1'b0, reti_v = 1'b0, rst_v = 1'b1;

  // reference model: pin history by age, pending/in-service sets, mode 0=idle 1=requesting 2=vectoring
  logic [3:0]  m_pin1, m_pin2, m_pin3, m_pend, m_isr, m_mask;
  int          m_mode;
  logic [1:0]  m_id;
  logic        m_req, m_vv, m_err;
  logic [11:0] m_vaddr;

  logic [28:0] exp_q[$];
  logic [11:0] vec_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pin1 = '0; m_pin2 = '0; m_pin3 = '0; m_pend = '0; m_isr = '0; m_mask = 4'hF;
    m_mode = 0; m_id = '0; m_req = 0; m_vv = 0; m_err = 0; m_vaddr = '0;
  endtask

  task automatic model_step();
    logic [3:0] newly, took, retired;
    int winner, top;
    if (rst_v) begin
      model_reset();
      return;
    end
    newly   = m_pin2 & ~m_pin3;
    took    = '0;
    retired = '0;
    winner  = 4;
    top     = 4;
    for (int i = 3; i >= 0; i--) begin
      if (m_pend[i] && !m_mask[i]) winner = i;
      if (m_isr[i]) top = i;
    end
    m_vv = 0;
    if (m_mode == 0) begin
      if (ien_v && winner < top) begin
        m_mode = 1; m_id = 2'(winner); m_req = 1;
      end
    end else if (m_mode == 1) begin
      if (ack_v) begin
        took[m_id] = 1'b1;
        m_mode = 2; m_req = 0; m_vv = 1;
        m_vaddr = 12'(32'hF00 + 4 * int'(m_id));
        vec_q.push_back(m_vaddr);
      end else if (!ien_v || m_mask[m_id]) begin
        m_mode = 0; m_req = 0;
      end
    end else begin
      m_mode = 0;
    end
    if (reti_v) begin
      if (top < 4) retired[top] = 1'b1;
      else m_err = 1;
    end
    m_pend = (m_pend & ~took) | newly;
    m_isr  = (m_isr & ~retired) | took;
    if (mwr_v) m_mask = mdata_v;
    m_pin3 = m_pin2; m_pin2 = m_pin1; m_pin1 = irq_v;
  endtask

  // one clock: called just after a falling edge, returns just after the next falling edge
  task automatic cyc();
    RST = rst_v; IRQ_IN = irq_v; IEN = ien_v; MASK_WR = mwr_v; MASK_DATA = mdata_v;
    INT_ACK = ack_v; RETI = reti_v;
    model_step();
    exp_q.push_back({m_req, m_id, m_vv, m_vaddr, m_pend, m_isr, m_mask, m_err});
    @(posedge clk);
    @(negedge clk);
    mwr_v = 0; ack_v = 0; reti_v = 0;
  endtask

  // monitor: every output bundle after each edge, plus vector scoreboard on VECTOR_VALID
  initial begin
    logic [28:0] e, a;
    logic [11:0] ev;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {INT_REQ, INT_ID, VECTOR_VALID, VECTOR_ADDR, PENDING, IN_SERVICE, MASK_Q, RETI_ERR};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs: got req=%b id=%0d vv=%b va=%h pend=%b isr=%b mask=%b err=%b expected req=%b id=%0d vv=%b va=%h pend=%b isr=%b mask=%b err=%b at %0t",
                   a[28], a[27:26], a[25], a[24:13], a[12:9], a[8:5], a[4:1], a[0],
                   e[28], e[27:26], e[25], e[24:13], e[12:9], e[8:5], e[4:1], e[0], $time);
        end
      end
      if (VECTOR_VALID === 1'b1) begin
        total++;
        if (vec_q.size() == 0) begin
          bad++;
          $display("FAIL vector: got unexpected pulse addr=%h expected none at %0t", VECTOR_ADDR, $time);
        end else begin
          ev = vec_q.pop_front();
          if (VECTOR_ADDR !== ev) begin
            bad++;
            $display("FAIL vector: got addr=%h expected %h at %0t", VECTOR_ADDR, ev, $time);
          end
        end
      end
    end
  end

  initial begin
    RST = 1; IRQ_IN = '0; IEN = 0; MASK_WR = 0; MASK_DATA = '0; INT_ACK = 0; RETI = 0;
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    check("reset_mask", int'(MASK_Q), 'hF);
    check("reset_req", int'(INT_REQ), 0);

    // single request on line 2, then acknowledge
    rst_v = 0; ien_v = 1; mwr_v = 1; mdata_v = '0;
    cyc();
    irq_v = 4'b0100;
    cyc(); cyc(); cyc();
    check("req_early", int'(INT_REQ), 0);
    cyc();
    check("req_line2", int'(INT_REQ), 1);
    check("id_line2", int'(INT_ID), 2);
    ack_v = 1; cyc();
    check("vec_valid", int'(VECTOR_VALID), 1);
    check("vec_addr2", int'(VECTOR_ADDR), 'hF08);
    check("isr_line2", int'(IN_SERVICE), 'b0100);
    check("pend_clear", int'(PENDING), 0);

    // nesting: line 3 blocked behind line 2, line 0 preempts
    irq_v = 4'b1100;
    repeat (5) cyc();
    check("nest_block", int'(INT_REQ), 0);
    irq_v = 4'b1101;
    repeat (4) cyc();
    check("nest_id0", int'(INT_ID), 0);
    ack_v = 1; cyc();
    check("nest_isr", int'(IN_SERVICE), 'b0101);
    reti_v = 1; cyc();
    check("reti_isr", int'(IN_SERVICE), 'b0100);
    reti_v = 1; cyc();
    cyc(); cyc();
    check("line3_req", int'(INT_ID), 3);
    ack_v = 1; cyc();
    check("vec_addr3", int'(VECTOR_ADDR), 'hF0C);
    reti_v = 1; cyc();
    reti_v = 1; cyc();
    check("reti_err", int'(RETI_ERR), 1);

    // masked request, then IEN drop while requesting
    irq_v = 4'b0000; mwr_v = 1; mdata_v = 4'b0010; cyc();
    irq_v = 4'b0010;
    repeat (5) cyc();
    check("mask_pend", int'(PENDING), 'b0010);
    check("mask_noreq", int'(INT_REQ), 0);
    mwr_v = 1; mdata_v = 4'b0000; cyc();
    check("unmask_wait", int'(INT_REQ), 0);
    cyc();
    check("unmask_req", int'(INT_REQ), 1);
    ien_v = 0; cyc();
    check("ien_drop_req", int'(INT_REQ), 0);
    check("ien_drop_pend", int'(PENDING), 'b0010);
    ien_v = 1; cyc();
    check("rereq", int'(INT_REQ), 1);

    // asynchronous reset while requesting
    #2 RST = 1;
    #1;
    check("async_req", int'(INT_REQ), 0);
    check("async_mask", int'(MASK_Q), 'hF);
    check("async_pend", int'(PENDING), 0);
    rst_v = 1;
    @(negedge clk);
    cyc();
    rst_v = 0; mwr_v = 1; mdata_v = '0; irq_v = '0;
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) irq_v[b] = ~irq_v[b];
      ien_v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 14) == 0) begin
        mwr_v = 1; mdata_v = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      end
      ack_v  = (m_mode == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      reti_v = ($urandom_range(0, 11) == 0);
      cyc();
    end
    ien_v = 0;
    repeat (3) cyc();
    check("vec_drain", vec_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
